// File: rtl/layer_tm.sv
// Time-multiplexed fully-connected layer: NUM_PE shared MAC units sweep the neurons group by group.
// Weights and biases sit in internal memories loaded over the layer/neuron-addressed config bus.
module layer_tm #(
    parameter int unsigned NUM_INPUTS       = 30,
    parameter int unsigned NUM_NEURONS      = 16,
    parameter int unsigned NUM_PE           = 4,
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned WEIGHT_INT_WIDTH = 4,
    parameter int unsigned LAYER_NUM        = 1,
    parameter string       ACT_TYPE         = "relu"
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              weight_valid,
    input  logic                              bias_valid,
    input  logic [31:0]                       weight_value,
    input  logic [31:0]                       bias_value,
    input  logic [31:0]                       config_layer_num,
    input  logic [31:0]                       config_neuron_num,
    input  logic                              x_valid,
    output logic                              x_ready,
    input  logic [DATA_WIDTH-1:0]             x_in,
    output logic                              o_valid,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] x_out,
    output logic                              busy,
    output logic                              cfg_err
);

    localparam int unsigned NumGroups = NUM_NEURONS / NUM_PE;
    localparam int unsigned Frac      = DATA_WIDTH - WEIGHT_INT_WIDTH;
    localparam int unsigned AccWidth  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS);
    localparam int unsigned CntWidth  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned GrpWidth  = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int unsigned NrnWidth  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam bit          IsRelu    = (ACT_TYPE == "relu");

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(NUM_INPUTS - 1);
    localparam logic [GrpWidth-1:0] GrpLast = GrpWidth'(NumGroups - 1);

    localparam logic signed [AccWidth:0] SatMax =
        {{(AccWidth - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AccWidth:0] SatMin =
        {{(AccWidth - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OutMax = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OutMin = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCompute = 2'd1;
    localparam logic [1:0] StFinal   = 2'd2;

    if ((NUM_NEURONS % NUM_PE) != 0) begin : gen_bad_pe
        $error("layer_tm: NUM_NEURONS must be a multiple of NUM_PE");
    end

    logic [1:0]                 state_q;
    logic [CntWidth-1:0]        cnt_q;
    logic [CntWidth-1:0]        k_q;
    logic [GrpWidth-1:0]        grp_q;
    logic                       o_valid_q;
    logic                       cfg_err_q;
    logic signed [AccWidth-1:0] acc_q [NUM_PE];
    logic [DATA_WIDTH-1:0]      out_q [NUM_NEURONS];

    // Memories are data only and deliberately survive reset.
    logic [DATA_WIDTH-1:0]      weight_q [NUM_NEURONS][NUM_INPUTS];
    logic [DATA_WIDTH-1:0]      bias_q   [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]      buf_q    [NUM_INPUTS];
    logic [CntWidth-1:0]        wptr_q   [NUM_NEURONS];

    logic                         layer_hit;
    logic                         nrn_ok;
    logic                         cfg_apply;
    logic                         w_we;
    logic                         b_we;
    logic                         cfg_drop;
    logic [NrnWidth-1:0]          cfg_nidx;
    logic                         x_accept;
    logic [NrnWidth-1:0]          pe_nidx [NUM_PE];
    logic signed [2*DATA_WIDTH-1:0] pe_prod [NUM_PE];
    logic [DATA_WIDTH-1:0]        pe_res  [NUM_PE];
    logic                         unused_cfg_bits;

    assign x_ready = (state_q == StIdle);
    assign busy    = (state_q != StIdle);
    assign o_valid = o_valid_q;
    assign cfg_err = cfg_err_q;

    assign layer_hit = (config_layer_num == 32'(LAYER_NUM));
    assign nrn_ok    = (config_neuron_num < 32'(NUM_NEURONS));
    assign cfg_nidx  = NrnWidth'(config_neuron_num);
    assign cfg_apply = layer_hit && nrn_ok && (state_q == StIdle);
    assign w_we      = weight_valid && cfg_apply;
    assign b_we      = bias_valid && cfg_apply;
    assign cfg_drop  = (weight_valid || bias_valid) && layer_hit && (!nrn_ok || busy);
    assign x_accept  = x_valid && (state_q == StIdle);

    // Only the low DATA_WIDTH bits of the config values carry data.
    assign unused_cfg_bits = ^{weight_value, bias_value};

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : gen_out
        assign x_out[n*DATA_WIDTH +: DATA_WIDTH] = out_q[n];
    end

    for (genvar p = 0; p < NUM_PE; p++) begin : gen_pe
        logic signed [AccWidth-1:0] shifted;
        logic signed [AccWidth:0]   sum;
        logic [DATA_WIDTH-1:0]      bias_v;
        logic [DATA_WIDTH-1:0]      sat;

        assign pe_nidx[p] = NrnWidth'(int'(grp_q) * NUM_PE + p);
        assign pe_prod[p] = (2*DATA_WIDTH)'($signed(buf_q[k_q]))
                          * (2*DATA_WIDTH)'($signed(weight_q[pe_nidx[p]][k_q]));

        assign bias_v  = bias_q[pe_nidx[p]];
        assign shifted = acc_q[p] >>> Frac;
        // One guard bit so the bias add itself can never wrap before saturation.
        assign sum = {shifted[AccWidth-1], shifted}
                   + {{(AccWidth + 1 - DATA_WIDTH){bias_v[DATA_WIDTH-1]}}, bias_v};

        always_comb begin
            if (sum > SatMax) begin
                sat = OutMax;
            end else if (sum < SatMin) begin
                sat = OutMin;
            end else begin
                sat = sum[DATA_WIDTH-1:0];
            end
        end

        assign pe_res[p] = (IsRelu && sat[DATA_WIDTH-1]) ? '0 : sat;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            weight_q[cfg_nidx][wptr_q[cfg_nidx]] <= weight_value[DATA_WIDTH-1:0];
        end
        if (b_we) begin
            bias_q[cfg_nidx] <= bias_value[DATA_WIDTH-1:0];
        end
        if (x_accept) begin
            buf_q[cnt_q] <= x_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                wptr_q[n] <= '0;
            end
        end else if (w_we) begin
            wptr_q[cfg_nidx] <= (wptr_q[cfg_nidx] == CntLast) ? '0
                              : wptr_q[cfg_nidx] + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            k_q       <= '0;
            grp_q     <= '0;
            o_valid_q <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int p = 0; p < NUM_PE; p++) begin
                acc_q[p] <= '0;
            end
            for (int n = 0; n < NUM_NEURONS; n++) begin
                out_q[n] <= '0;
            end
        end else begin
            o_valid_q <= 1'b0;
            if (cfg_drop) begin
                cfg_err_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (x_valid) begin
                        if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            k_q     <= '0;
                            grp_q   <= '0;
                            state_q <= StCompute;
                            for (int p = 0; p < NUM_PE; p++) begin
                                acc_q[p] <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntWidth'(1);
                        end
                    end
                end
                StCompute: begin
                    for (int p = 0; p < NUM_PE; p++) begin
                        acc_q[p] <= acc_q[p] + AccWidth'(pe_prod[p]);
                    end
                    if (k_q == CntLast) begin
                        state_q <= StFinal;
                    end else begin
                        k_q <= k_q + CntWidth'(1);
                    end
                end
                StFinal: begin
                    for (int p = 0; p < NUM_PE; p++) begin
                        out_q[pe_nidx[p]] <= pe_res[p];
                        acc_q[p]          <= '0;
                    end
                    k_q <= '0;
                    if (grp_q == GrpLast) begin
                        state_q   <= StIdle;
                        o_valid_q <= 1'b1;
                    end else begin
                        grp_q   <= grp_q + GrpWidth'(1);
                        state_q <= StCompute;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/layer_tm.md
Name: layer_tm

Overview:
- Time-multiplexed fully-connected layer for the fraud-detection MLP.
- Computes NUM_NEURONS neuron outputs from one NUM_INPUTS-sample serial input vector, using NUM_PE shared MAC units over NUM_NEURONS/NUM_PE groups.
- Weights and biases live in internal memories, written through the existing layer/neuron-addressed config bus.
- Drops in between layers wherever a full parallel neuron array is too large for the FPGA.

Parameters:
- NUM_INPUTS, 30, input samples per vector (weights per neuron).
- NUM_NEURONS, 16, neurons in the layer.
- NUM_PE, 4, parallel MAC units. NUM_NEURONS must be a multiple of NUM_PE; elaboration error otherwise.
- DATA_WIDTH, 16, signed two's-complement width of inputs, weights, biases and outputs.
- WEIGHT_INT_WIDTH, 4, integer bits including sign. F = DATA_WIDTH-WEIGHT_INT_WIDTH fractional bits.
- LAYER_NUM, 1, layer id matched against config_layer_num.
- ACT_TYPE, "relu", "relu" or "linear".

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- weight_valid  in  1  weight write strobe
- bias_valid  in  1  bias write strobe
- weight_value  in  32  weight; low DATA_WIDTH bits used
- bias_value  in  32  bias; low DATA_WIDTH bits used
- config_layer_num  in  32  target layer of the write
- config_neuron_num  in  32  target neuron of the write
- x_valid  in  1  input sample valid
- x_ready  out  1  input sample accepted when x_valid&x_ready
- x_in  in  DATA_WIDTH  input sample
- o_valid  out  1  one-cycle pulse: x_out updated
- x_out  out  NUM_NEURONS*DATA_WIDTH  neuron n at [n*DATA_WIDTH+:DATA_WIDTH]
- busy  out  1  high in COMPUTE/FINAL
- cfg_err  out  1  sticky: a config write was dropped

Behaviour:
- Reset values:
  - o_valid=0, x_out=0, busy=0, cfg_err=0, x_ready=1.
  - State IDLE; input count, group index, MAC index and all write pointers = 0.
  - Weight and bias memory contents are not cleared.
- Reset mid-operation aborts the computation. Partial input vectors are discarded.
- Config writes:
  - A write applies when its strobe is high, config_layer_num==LAYER_NUM and state is IDLE.
  - Weight writes go to neuron config_neuron_num at that neuron's weight pointer. The pointer increments and wraps to 0 after NUM_INPUTS writes.
  - Bias writes overwrite that neuron's bias.
  - weight_valid and bias_valid in the same cycle are both applied.
  - Dropped writes set cfg_err and leave memory unchanged:
    - a layer-matched write while busy=1;
    - a layer-matched write with config_neuron_num>=NUM_NEURONS.
  - A write with a non-matching layer is ignored silently.
- States:
  - IDLE: x_ready=1. Each accepted sample goes to buffer[count] and count increments. Accepting sample NUM_INPUTS-1 sets count=0, group=0, k=0, clears accumulators, and moves to COMPUTE. x_ready is low from the next cycle.
  - COMPUTE: for each PE p, acc_p += buffer[k]*W[group*NUM_PE+p][k]. Products are full 2*DATA_WIDTH signed. The accumulator is 2*DATA_WIDTH+clog2(NUM_INPUTS) bits with no intermediate overflow. k increments; after k==NUM_INPUTS-1, go to FINAL.
  - FINAL (1 cycle), per PE:
    - r = (acc_p >>> F) + sign-extended bias (arithmetic shift, truncation toward -inf).
    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - relu: negative -> 0.
    - Write to the x_out slice.
    - If group==NUM_NEURONS/NUM_PE-1, go to IDLE and pulse o_valid. Otherwise group++, k=0, clear accumulators, return to COMPUTE.
- Latency: with G=NUM_NEURONS/NUM_PE, o_valid is high for exactly one cycle, starting G*(NUM_INPUTS+1) edges after the edge that accepted the last sample.
  - x_ready is high again in that same cycle; a new vector may begin streaming immediately.
  - x_out holds its value until the next FINAL writes it. Partially updated slices are visible during compute; consumers use only o_valid.
- x_valid while x_ready=0 is not accepted; the sample must be held by the source.

Test Plan:
Common configuration: NUM_INPUTS=4, NUM_NEURONS=4, NUM_PE=2, DATA_WIDTH=16, WEIGHT_INT_WIDTH=4; 1.0 = 0x1000.
1. Basic MAC and latency:
   - Stimulus: load neuron0 weights 0x1000 x4, bias 0x0000; stream inputs 0x1000, 0x0800, 0x0400, 0x0000.
   - Required: x_out[15:0]=0x1C00; o_valid pulses exactly 10 edges after the 4th accept.
2. Activation and bias:
   - Stimulus: neuron1 weights 0xF000 x4, bias 0x0100, same inputs.
   - Required: relu gives 0x0000; ACT_TYPE="linear" gives 0xE500.
3. Saturation:
   - Stimulus: neuron2 weights 0x7FFF, inputs 0x7FFF.
   - Required: 0x7FFF. With weights 0x8000 and linear: 0x8000.
4. Config gating:
   - Stimulus: write with config_layer_num=2; then a write while busy; then config_neuron_num=4.
   - Required: first is ignored, cfg_err stays 0. Second and third are dropped with cfg_err=1. Recomputed outputs are unchanged.
5. Reset mid-compute:
   - Stimulus: assert rst during COMPUTE of group 1.
   - Required: o_valid, busy and x_out are 0 immediately and x_ready=1. A fresh vector after release reproduces scenario 1 results without reloading weights.
6. Back-to-back vectors:
   - Stimulus: hold x_valid=1 with 8 samples queued.
   - Required: x_ready is 0 for 10 cycles after the 4th accept and re-rises in the same cycle as the o_valid pulse. Two o_valid pulses occur, with both vectors' correct results.
